// File: rtl/mac6_seq_pkg.sv
// Shared definitions for the 6x6 signed sequential multiply-accumulate block:
// FSM encoding, default vector length and accumulator saturation limits.
package mac6_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,   // no vector open
      ST_ACCUM = 2'd1,   // vector open, beats being accumulated
      ST_HOLD  = 2'd2    // result pending for downstream
   } state_t;

   localparam int MAX_LEN_DEF = 16;
   localparam int ACC_MAX     = 2047;
   localparam int ACC_MIN     = -2048;

   typedef struct packed {
      logic signed [11:0] val;
      logic               sat;
   } sat_t;

   // Clamp a 13-bit raw beat result into the 12-bit accumulator range.
   function automatic sat_t sat12(input logic signed [12:0] r);
      sat_t res;
      if (int'(r) > ACC_MAX) begin
         res.val = 12'(ACC_MAX);
         res.sat = 1'b1;
      end else if (int'(r) < ACC_MIN) begin
         res.val = 12'(ACC_MIN);
         res.sat = 1'b1;
      end else begin
         res.val = r[11:0];
         res.sat = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/mac6_seq_mac6.sv
// Combinational beat arithmetic: r = A*B + (MODE ? -ACC : ACC), 13-bit signed.
// Widths are chosen so no intermediate can overflow: |A*B| <= 1024 and
// |ACC| <= 2048, so the sum always fits in 13 bits.
module mac6 (
   input  logic signed [5:0]  a,
   input  logic signed [5:0]  b,
   input  logic               mode,
   input  logic signed [11:0] acc,
   output logic signed [12:0] r
);
   import mac6_seq_pkg::*;

   logic signed [11:0] prod;
   logic signed [12:0] prod_ext;
   logic signed [12:0] acc_ext;

   // Sign-extend both terms to 13 bits, then add or subtract the accumulator.
   always_comb begin
      prod     = a * b;
      prod_ext = {prod[11], prod};
      acc_ext  = {acc[11], acc};
      r        = mode ? (prod_ext - acc_ext) : (prod_ext + acc_ext);
   end

endmodule

// File: rtl/mac6_seq.sv
// Sequential saturating MAC over vectors of up to MAX_LEN beats with a
// valid/ready input stream and a single-entry held result on the output.
module mac6_seq
   import mac6_seq_pkg::*;
#(
   parameter int MAX_LEN = MAX_LEN_DEF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [5:0]  IN_A,
   input  logic [5:0]  IN_B,
   input  logic        IN_MODE,
   input  logic        IN_LAST,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [11:0] OUT_DATA,
   output logic [4:0]  OUT_LEN,
   output logic        OUT_OVF,
   output logic        OUT_TRUNC
);

   state_t             state_q, state_d;
   logic signed [11:0] acc_q, acc_d;
   logic [4:0]         count_q, count_d;
   logic               ovf_q, ovf_d;
   logic [11:0]        out_data_q, out_data_d;
   logic [4:0]         out_len_q, out_len_d;
   logic               out_ovf_q, out_ovf_d;
   logic               out_trunc_q, out_trunc_d;

   logic               accept;
   logic               closing;
   logic signed [11:0] acc_in;
   logic signed [12:0] raw_r;
   sat_t               sat_r;
   logic [4:0]         count_inc;

   // First beat of a vector always starts from zero, whatever acc holds.
   assign acc_in = (state_q == ST_IDLE) ? 12'sd0 : acc_q;

   mac6 u_mac6 (
      .a    ($signed(IN_A)),
      .b    ($signed(IN_B)),
      .mode (IN_MODE),
      .acc  (acc_in),
      .r    (raw_r)
   );

   // Handshake, saturation and vector-closing conditions for this cycle.
   always_comb begin
      accept    = IN_VALID && IN_READY;
      sat_r     = sat12(raw_r);
      count_inc = count_q + 5'd1;
      closing   = IN_LAST || (count_inc == 5'(MAX_LEN));
   end

   // FSM state register.
   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_ACCUM: if (accept) state_d = closing ? ST_HOLD : ST_ACCUM;
         ST_HOLD:           if (OUT_READY) state_d = ST_IDLE;
         default:           state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: ready while a vector can take beats, valid while holding.
   always_comb begin
      IN_READY  = (state_q != ST_HOLD);
      OUT_VALID = (state_q == ST_HOLD);
   end

   // Datapath next values: accumulate on accepted beats, capture on close,
   // clear the running vector once downstream takes the result.
   always_comb begin
      acc_d       = acc_q;
      count_d     = count_q;
      ovf_d       = ovf_q;
      out_data_d  = out_data_q;
      out_len_d   = out_len_q;
      out_ovf_d   = out_ovf_q;
      out_trunc_d = out_trunc_q;
      if (accept) begin
         acc_d   = sat_r.val;
         count_d = count_inc;
         ovf_d   = ovf_q || sat_r.sat;
         if (closing) begin
            out_data_d  = sat_r.val;
            out_len_d   = count_inc;
            out_ovf_d   = ovf_q || sat_r.sat;
            out_trunc_d = !IN_LAST;
         end
      end else if ((state_q == ST_HOLD) && OUT_READY) begin
         acc_d   = 12'sd0;
         count_d = 5'd0;
         ovf_d   = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         acc_q       <= 12'sd0;
         count_q     <= 5'd0;
         ovf_q       <= 1'b0;
         out_data_q  <= 12'd0;
         out_len_q   <= 5'd0;
         out_ovf_q   <= 1'b0;
         out_trunc_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         count_q     <= count_d;
         ovf_q       <= ovf_d;
         out_data_q  <= out_data_d;
         out_len_q   <= out_len_d;
         out_ovf_q   <= out_ovf_d;
         out_trunc_q <= out_trunc_d;
      end
   end

   assign OUT_DATA  = out_data_q;
   assign OUT_LEN   = out_len_q;
   assign OUT_OVF   = out_ovf_q;
   assign OUT_TRUNC = out_trunc_q;

endmodule

// File: doc/mac6_seq.md
MAC6_SEQ -- requirements
Module: mac6_seq

Interface
- REQ-001 SHALL have parameter: MAX_LEN, 16, maximum beats per vector (legal range 2..16).
- REQ-002 SHALL have port: CLK  input  1  sole clock; all state updates on rising edge.
- REQ-003 SHALL have port: RST  input  1  synchronous, active-high reset.
- REQ-004 SHALL have port: IN_VALID  input  1  operand beat present.
- REQ-005 SHALL have port: IN_READY  output  1  block accepts beat this cycle.
- REQ-006 SHALL have port: IN_A, IN_B  input  6 each  signed two's-complement operands.
- REQ-007 SHALL have port: IN_MODE  input  1  0: acc+A*B; 1: A*B-acc.
- REQ-008 SHALL have port: IN_LAST  input  1  final beat of vector.
- REQ-009 SHALL have port: OUT_VALID  output  1  result held.
- REQ-010 SHALL have port: OUT_READY  input  1  downstream takes result.
- REQ-011 SHALL have port: OUT_DATA  output  12  signed saturated result.
- REQ-012 SHALL have port: OUT_LEN  output  5  beats in vector (1..MAX_LEN).
- REQ-013 SHALL have port: OUT_OVF  output  1  saturation occurred at any beat of vector.
- REQ-014 SHALL have port: OUT_TRUNC  output  1  vector closed by MAX_LEN, not IN_LAST.

Function
- REQ-015 SHALL implement FSM states IDLE (no vector open), ACCUM (vector open), HOLD (result pending).
- REQ-016 SHALL accept beat when IN_VALID & IN_READY; IN_READY = 1 in IDLE/ACCUM, 0 in HOLD.
- REQ-017 SHALL compute per beat r = A*B + (MODE ? -acc : acc), 13-bit signed, acc = 0 for first beat of vector.
- REQ-018 SHALL saturate r to 12 bits: r>2047 -> 2047, r<-2048 -> -2048; saturation sets sticky vector OVF.
- REQ-019 SHALL register saturated r into acc at accepting edge; beat count increments same edge.
- REQ-020 SHALL close vector on accepted beat with IN_LAST=1 or count reaching MAX_LEN; TRUNC=1 only in latter case without IN_LAST.
- REQ-021 SHALL, on closing edge, load OUT_DATA/LEN/OVF/TRUNC and enter HOLD; OUT_VALID high the following cycle (latency 1 cycle from last acceptance).
- REQ-022 SHALL hold all OUT_* stable while OUT_VALID & !OUT_READY.
- REQ-023 SHALL, on OUT_VALID & OUT_READY edge, drop OUT_VALID, clear acc/count/flags, go IDLE; new beat accepted the next cycle earliest.
- REQ-024 SHALL treat IN_VALID=0 in ACCUM as a stall: acc/count unchanged, no timeout.
- REQ-025 SHALL, in IDLE, go ACCUM on accepted non-closing beat, HOLD on accepted closing beat (single-beat vector).
- REQ-026 SHALL ignore IN_* contents when no handshake occurs.

Reset
- REQ-027 SHALL, when RST=1 at an edge, set state IDLE, acc 0, count 0, OUT_VALID 0, OUT_DATA 0, OUT_LEN 0, OUT_OVF 0, OUT_TRUNC 0, IN_READY 1 next cycle.
- REQ-028 SHALL let RST override simultaneous handshakes; reset mid-vector or in HOLD discards partial/pending result.

Structure
- REQ-029 SHALL place state encodings, MAX_LEN default, ACC_MAX=2047, ACC_MIN=-2048 in shared package mac6_seq_pkg.
- REQ-030 SHALL instantiate MAC6 as sole sub-module for r (A=IN_A, B=IN_B, MODE=IN_MODE, ACC=acc-or-0); saturation, counters, FSM in mac6_seq.

Verification
- REQ-031 SHALL cover: beat (3,4,0,LAST) -> next cycle OUT_VALID=1, DATA=12, LEN=1, OVF=0, TRUNC=0.
- REQ-032 SHALL cover: beats (31,31,0)x3, last with LAST -> DATA=2047, LEN=3, OVF=1 (raw 2883).
- REQ-033 SHALL cover: beats (2,5,0),(1,1,1,LAST) -> DATA=-9, LEN=2.
- REQ-034 SHALL cover: result pending, OUT_READY=0 for 3 cycles -> OUT_* stable, IN_READY=0; OUT_READY=1 -> OUT_VALID=0 next cycle.
- REQ-035 SHALL cover: 16 beats (1,1,0), no LAST -> DATA=16, LEN=16, TRUNC=1.
- REQ-036 SHALL cover: RST after 2 beats (5,5,0) -> all outputs 0; then (1,2,0,LAST) -> DATA=2, LEN=1.
